// File: rtl/f2s_pkg.sv
// Shared definitions for the fast-to-slow counter crossing: monitor state encoding,
// default widths and the gray-to-binary conversion used on both sides.
package f2s_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 4;
    localparam int unsigned DEFAULT_ACC_WIDTH = 16;

    typedef enum logic [1:0] {
        S_FILL,
        S_PRIME,
        S_RUN
    } state_e;

    // Operates on a zero-extended 32-bit word; callers truncate to their width.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int unsigned i = 0; i < 31; i++) begin
            b[30-i] = b[31-i] ^ g[30-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-bit flop chain synchronizer with asynchronous active-low reset.
module sync_ff_chain #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/f2s_count_monitor.sv
// Slow-domain monitor of a gray-coded fast counter: synchronizes, converts to binary,
// issues per-cycle increments and keeps a saturating event total with sticky error flags.
module f2s_count_monitor
    import f2s_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_STEP    = 3,
    parameter int unsigned ACC_WIDTH   = DEFAULT_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear,
    output logic [WIDTH-1:0]     bin_out,
    output logic [WIDTH-1:0]     delta_out,
    output logic                 delta_valid,
    output logic [ACC_WIDTH-1:0] total_out,
    output logic                 step_err,
    output logic                 acc_ovf
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);
    localparam int unsigned SUM_W = ACC_WIDTH + 1;

    logic [WIDTH-1:0] sync_gray;

    sync_ff_chain #(
        .WIDTH(WIDTH),
        .DEPTH(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(reset),
        .d    (gray_in),
        .q    (sync_gray)
    );

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     fill_cnt_q, fill_cnt_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic [WIDTH-1:0]     delta_q, delta_d;
    logic                 valid_q, valid_d;
    logic [ACC_WIDTH-1:0] total_q, total_d;
    logic                 step_err_q, step_err_d;
    logic                 acc_ovf_q, acc_ovf_d;
    logic [WIDTH-1:0]     delta;
    logic [SUM_W-1:0]     sum;

    always_comb begin
        bin_d      = WIDTH'(gray2bin(32'(sync_gray)));
        delta      = bin_q - prev_q;
        sum        = {1'b0, total_q} + SUM_W'(delta);
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        prev_d     = prev_q;
        delta_d    = '0;
        valid_d    = 1'b0;
        total_d    = total_q;
        step_err_d = step_err_q;
        acc_ovf_d  = acc_ovf_q;

        case (state_q)
            S_FILL: begin
                if (fill_cnt_q == CNT_W'(SYNC_STAGES)) begin
                    state_d = S_PRIME;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            S_PRIME: begin
                prev_d  = bin_q;
                state_d = S_RUN;
            end
            S_RUN: begin
                prev_d  = bin_q;
                delta_d = delta;
                if (delta != '0) begin
                    valid_d = 1'b1;
                    if (sum[ACC_WIDTH]) begin
                        total_d   = '1;
                        acc_ovf_d = 1'b1;
                    end else begin
                        total_d = sum[ACC_WIDTH-1:0];
                    end
                end
                if (delta > WIDTH'(MAX_STEP)) begin
                    step_err_d = 1'b1;
                end
            end
            default: state_d = S_FILL;
        endcase

        // Clear overrides any delta this cycle and re-primes so prev re-bases.
        if (clear && state_q != S_FILL) begin
            total_d    = '0;
            step_err_d = 1'b0;
            acc_ovf_d  = 1'b0;
            valid_d    = 1'b0;
            delta_d    = '0;
            state_d    = S_PRIME;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FILL;
            fill_cnt_q <= '0;
            bin_q      <= '0;
            prev_q     <= '0;
            delta_q    <= '0;
            valid_q    <= 1'b0;
            total_q    <= '0;
            step_err_q <= 1'b0;
            acc_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            bin_q      <= bin_d;
            prev_q     <= prev_d;
            delta_q    <= delta_d;
            valid_q    <= valid_d;
            total_q    <= total_d;
            step_err_q <= step_err_d;
            acc_ovf_q  <= acc_ovf_d;
        end
    end

    assign bin_out     = bin_q;
    assign delta_out   = delta_q;
    assign delta_valid = valid_q;
    assign total_out   = total_q;
    assign step_err    = step_err_q;
    assign acc_ovf     = acc_ovf_q;

endmodule

// File: tb/tb_f2s_count_monitor.sv
// Randomized bench for f2s_count_monitor: a default instance and a 4-bit-total instance
// share one stimulus stream and are compared against a sample-history model.
module tb_f2s_count_monitor;

    localparam int S    = 2;
    localparam int MAXS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  gray_in;
    logic        clear;
    logic [3:0]  bin_out, delta_out, bin_out_s, delta_out_s;
    logic        delta_valid, step_err, acc_ovf;
    logic        delta_valid_s, step_err_s, acc_ovf_s;
    logic [15:0] total_out;
    logic [3:0]  total_out_s;

    always #5 clk = ~clk;

    f2s_count_monitor u_dut (
        .clk(clk), .reset(reset), .gray_in(gray_in), .clear(clear),
        .bin_out(bin_out), .delta_out(delta_out), .delta_valid(delta_valid),
        .total_out(total_out), .step_err(step_err), .acc_ovf(acc_ovf)
    );

    f2s_count_monitor #(.ACC_WIDTH(4)) u_dut_sat (
        .clk(clk), .reset(reset), .gray_in(gray_in), .clear(clear),
        .bin_out(bin_out_s), .delta_out(delta_out_s), .delta_valid(delta_valid_s),
        .total_out(total_out_s), .step_err(step_err_s), .acc_ovf(acc_ovf_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: binary value driven after each clk edge since the last reset release.
    int vals[$];
    int edge_n, ready_at, cur_val;
    int m_tot16, m_tot4;
    bit m_serr, m_ovf16, m_ovf4, clr_held;

    function automatic int get(input int idx);
        return (idx < 0) ? 0 : vals[idx];
    endfunction

    function automatic logic [3:0] to_gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic step(input int val, input bit clr);
        int  e, d;
        bit  exp_dv, in_run;
        @(posedge clk);
        edge_n++;
        #1;
        e      = edge_n;
        exp_dv = 0;
        in_run = 0;
        d      = 0;
        if (clr_held && e >= S + 2) begin
            m_tot16 = 0; m_tot4 = 0; m_serr = 0; m_ovf16 = 0; m_ovf4 = 0;
            ready_at = e + 2;
        end else if (e >= ready_at) begin
            in_run = 1;
            d      = (get(e - S - 2) - get(e - S - 3)) & 15;
            exp_dv = (d != 0);
            if (d > MAXS) m_serr = 1;
            if (m_tot16 + d > 65535) begin m_tot16 = 65535; m_ovf16 = 1; end
            else m_tot16 = m_tot16 + d;
            if (m_tot4 + d > 15) begin m_tot4 = 15; m_ovf4 = 1; end
            else m_tot4 = m_tot4 + d;
        end
        check("bin_out", 32'(bin_out), 32'(get(e - S - 1)));
        check("delta_valid", 32'(delta_valid), 32'(exp_dv));
        if (in_run) check("delta_out", 32'(delta_out), 32'(d));
        check("total_out", 32'(total_out), 32'(m_tot16));
        check("step_err", 32'(step_err), 32'(m_serr));
        check("acc_ovf", 32'(acc_ovf), 32'(m_ovf16));
        check("sat_total", 32'(total_out_s), 32'(m_tot4));
        check("sat_acc_ovf", 32'(acc_ovf_s), 32'(m_ovf4));
        gray_in  = to_gray(val);
        clear    = clr;
        vals.push_back(val);
        clr_held = clr;
        cur_val  = val;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear = 1'b0;
        #1;
        check("rst_bin", 32'(bin_out), 0);
        check("rst_delta", 32'(delta_out), 0);
        check("rst_valid", 32'(delta_valid), 0);
        check("rst_total", 32'(total_out), 0);
        check("rst_flags", {30'd0, step_err, acc_ovf}, 0);
        check("rst_sat_total", 32'(total_out_s), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        vals.delete();
        vals.push_back(cur_val);
        edge_n   = 0;
        ready_at = S + 3;
        m_tot16  = 0; m_tot4 = 0; m_serr = 0; m_ovf16 = 0; m_ovf4 = 0;
        clr_held = 0;
    endtask

    task automatic random_run(input int cycles);
        int v;
        v = cur_val;
        repeat (cycles) begin
            if ($urandom_range(0, 99) < 5) v = (v + $urandom_range(4, 15)) % 16;
            else v = (v + $urandom_range(0, 3)) % 16;
            step(v, $urandom_range(0, 99) < 4);
        end
    endtask

    initial begin
        int v;
        reset   = 1'b0;
        clear   = 1'b0;
        gray_in = '0;
        cur_val = 0;
        #2;
        do_reset();

        repeat (12) step(0, 0);

        v = 0;
        repeat (24) begin v = (v + 2) % 16; step(v, 0); end
        v = (v + 2) % 16; step(v, 1);
        repeat (6) begin v = (v + 2) % 16; step(v, 0); end

        repeat (5) step(12, 0);
        step(12, 1);
        repeat (4) step(12, 0);
        step(14, 0); step(0, 0); step(2, 0);
        repeat (6) step(2, 0);

        repeat (5) step(3, 0);
        step(9, 0);
        repeat (8) step(9, 0);

        do_reset();
        v = cur_val;
        repeat (10) begin v = (v + 2) % 16; step(v, 0); end
        v = (v + 2) % 16; step(v, 1);
        repeat (8) begin v = (v + 2) % 16; step(v, 0); end

        random_run(300);
        do_reset();
        random_run(60);
        repeat (8) step(cur_val, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
